// File: rtl/recv_img.sv
// recv_img: 8N1 UART receiver that writes bytes sequentially into the image BRAM.
// Ports: clk, rst_in_n (async active-low); rx serial in; send_busy blocks writes;
//        bram_addr/bram_din/bram_we BRAM write port; img_ready pulses after the last pixel;
//        busy spans first write to img_ready; frame_err pulses on a low stop bit;
//        overrun is sticky when a byte is dropped due to send_busy.
module recv_img #(
    parameter int CLOCKS_PER_BAUD = 50,
    parameter int IMG_PIXELS      = 32768,
    parameter int ADDR_W          = 15
) (
    input  logic              clk,
    input  logic              rst_in_n,
    input  logic              rx,
    input  logic              send_busy,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic              bram_we,
    output logic              img_ready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);
    localparam int CW = $clog2(CLOCKS_PER_BAUD);
    localparam logic [CW-1:0]     HALF = CW'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0]     FULL = CW'(CLOCKS_PER_BAUD - 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_PIXELS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t            state;
    logic              rx_meta;
    logic              rxs;
    logic [CW-1:0]     cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic [ADDR_W-1:0] pix;

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state     <= IDLE;
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            pix       <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
            bram_we   <= 1'b0;
            img_ready <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rxs       <= rx_meta;
            bram_we   <= 1'b0;
            frame_err <= 1'b0;
            // the write of the last pixel ends the image one cycle later
            img_ready <= bram_we && bram_addr == LAST;
            if (bram_we && bram_addr == LAST)
                busy <= 1'b0;
            case (state)
                IDLE:
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                START:
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else
                        cnt <= cnt + 1'b1;
                DATA:
                    if (cnt == FULL) begin
                        cnt     <= '0;
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end else
                        cnt <= cnt + 1'b1;
                STOP:
                    if (cnt == FULL) begin
                        cnt <= '0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end else begin
                            // back to IDLE at mid stop bit so a back-to-back start edge is caught
                            state <= IDLE;
                            if (send_busy)
                                overrun <= 1'b1;
                            else begin
                                bram_we   <= 1'b1;
                                bram_din  <= shift;
                                bram_addr <= pix;
                                pix       <= pix == LAST ? '0 : pix + 1'b1;
                                busy      <= 1'b1;
                            end
                        end
                    end else
                        cnt <= cnt + 1'b1;
                BREAK:
                    if (rxs)
                        state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_recv_img.sv
// tb_recv_img: randomized and directed checks of recv_img against a byte-level model.
module tb_recv_img;
    localparam int CPB  = 50;
    localparam int NPIX = 4;
    localparam int AW   = 15;

    logic          clk = 1'b0;
    logic          rst_in_n = 1'b0;
    logic          rx = 1'b1;
    logic          send_busy = 1'b0;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_din;
    logic          bram_we;
    logic          img_ready;
    logic          busy;
    logic          frame_err;
    logic          overrun;

    recv_img #(.CLOCKS_PER_BAUD(CPB), .IMG_PIXELS(NPIX), .ADDR_W(AW)) dut (
        .clk(clk), .rst_in_n(rst_in_n), .rx(rx), .send_busy(send_busy),
        .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
        .img_ready(img_ready), .busy(busy), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int            n_we = 0;
    int            n_rdy = 0;
    int            n_seq = 0;
    int            n_ferr = 0;
    logic [AW-1:0] last_addr = '0;
    logic [7:0]    last_din = '0;
    logic          prev_we_last = 1'b0;

    always @(negedge clk) begin
        if (bram_we) begin
            n_we      <= n_we + 1;
            last_addr <= bram_addr;
            last_din  <= bram_din;
        end
        if (img_ready) begin
            n_rdy <= n_rdy + 1;
            if (prev_we_last)
                n_seq <= n_seq + 1;
        end
        if (frame_err)
            n_ferr <= n_ferr + 1;
        prev_we_last <= bram_we && bram_addr == AW'(NPIX - 1);
    end

    int   m_cnt = 0;
    int   m_img = 0;
    int   m_ferr = 0;
    logic m_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic check_state();
        chk("img_ready_count", n_rdy, m_img);
        chk("img_ready_after_last", n_seq, m_img);
        chk("frame_err_count", n_ferr, m_ferr);
        chk("overrun", overrun, m_ovr);
        chk("busy", busy, m_cnt != 0);
    endtask

    task automatic send(input logic [7:0] d, input logic good, input int hold);
        int   w0;
        logic exp_w;
        w0    = n_we;
        exp_w = good && !send_busy;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++)
            bit_out(d[i]);
        bit_out(good);
        if (!good) begin
            rx = 1'b0;
            repeat (hold) @(posedge clk);
            #1;
            rx = 1'b1;
            repeat (4) @(posedge clk);
            #1;
        end
        chk("we_count", n_we - w0, exp_w);
        if (exp_w) begin
            chk("addr", last_addr, m_cnt);
            chk("din", last_din, d);
            if (m_cnt == NPIX - 1)
                m_img++;
            m_cnt = (m_cnt + 1) % NPIX;
        end
        if (!good)
            m_ferr++;
        else if (send_busy)
            m_ovr = 1'b1;
        check_state();
    endtask

    task automatic do_reset();
        rst_in_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_flags", {bram_we, img_ready, busy, frame_err, overrun}, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_din", bram_din, 0);
        rst_in_n = 1'b1;
        m_cnt = 0;
        m_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   w0;
        int   f0;
        logic good;
        #1;
        do_reset();
        send(8'hA5, 1'b1, 0);

        do_reset();
        for (int i = 1; i <= 4; i++)
            send(8'(i), 1'b1, 0);
        send(8'h55, 1'b1, 0);

        do_reset();
        send(8'h3C, 1'b0, 300);
        send(8'h77, 1'b1, 0);

        do_reset();
        w0 = n_we;
        f0 = n_ferr;
        rx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("glitch_we", n_we - w0, 0);
        chk("glitch_ferr", n_ferr - f0, 0);
        chk("glitch_busy", busy, 0);
        send(8'h5A, 1'b1, 0);

        do_reset();
        send_busy = 1'b1;
        send(8'h11, 1'b1, 0);
        send_busy = 1'b0;
        send(8'h22, 1'b1, 0);

        do_reset();
        send(8'hC3, 1'b1, 0);
        send(8'h3C, 1'b1, 0);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        #1 rst_in_n = 1'b0;
        #1;
        chk("async_rst_flags", {bram_we, img_ready, busy, frame_err, overrun}, 0);
        chk("async_rst_addr", bram_addr, 0);
        #1 rst_in_n = 1'b1;
        m_cnt = 0;
        m_ovr = 1'b0;
        rx = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        check_state();
        send(8'h9E, 1'b1, 0);
        for (int i = 0; i < 3; i++)
            send(8'($urandom), 1'b1, 0);

        for (int i = 0; i < 30; i++) begin
            send_busy = $urandom_range(0, 3) == 0;
            good = $urandom_range(0, 5) != 0;
            send(8'($urandom), good, int'($urandom_range(20, 200)));
        end
        send_busy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/recv_img.md
Name: recv_img

Overview:
UART image receiver that sits directly upstream of the image transmitter. It deserializes 8N1 bytes from the host on rx and writes each valid byte sequentially into the 8-bit-wide image BRAM through its write port. After the last pixel is written it pulses img_ready, which drives the transmitter's full-image-received input. Bytes that arrive while the transmitter is reading the BRAM are dropped and flagged, so the image being sent is never corrupted.

Parameters:
CLOCKS_PER_BAUD, 50, clk cycles per UART bit; must be ≥4 and even.
IMG_PIXELS, 32768, bytes per image; must be ≤2^ADDR_W.
ADDR_W, 15, BRAM address width.

Ports:
clk  in  1  system clock.
rst_in_n  in  1  reset; asynchronous, active-low.
rx  in  1  UART serial input, asynchronous, idles high.
send_busy  in  1  high while the downstream transmitter owns the BRAM.
bram_addr  out  ADDR_W  BRAM write address.
bram_din  out  8  BRAM write data.
bram_we  out  1  BRAM write enable, one-cycle pulse per byte.
img_ready  out  1  one-cycle pulse when a full image has been written.
busy  out  1  high from the first accepted byte of an image until img_ready.
frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
overrun  out  1  sticky flag, set when a byte is dropped due to send_busy; cleared only by reset.

Behaviour:
- Reset (rst_in_n=0, async): state=IDLE; pixel count=0; bit/baud counters=0; all outputs 0; the rx synchronizer presets to 1.
- rx passes through a 2-flop synchronizer. The synchronized signal is called rxs. All sampling uses rxs.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: when rxs=0, go to START and clear the baud counter.
- START: at count CLOCKS_PER_BAUD/2-1, sample rxs.
  - rxs=1: glitch, return to IDLE.
  - rxs=0: go to DATA, bit index=0, clear baud counter.
- DATA: sample rxs every CLOCKS_PER_BAUD cycles, at mid-bit. Bits arrive LSB first into a shift register. After the 8th sample, go to STOP.
- STOP: sample rxs at mid-bit, one CLOCKS_PER_BAUD after the last data sample.
  - rxs=1 and send_busy=0: the next cycle has bram_we=1, bram_din=byte, bram_addr=pixel count. Then go to IDLE.
  - rxs=1 and send_busy=1: no write, count unchanged, set overrun. Go to IDLE.
  - rxs=0: pulse frame_err for one cycle. No write, count unchanged. Go to BREAK.
- BREAK: stay until rxs=1, then go to IDLE. A held-low line never retriggers a start.
- The return to IDLE happens at mid stop bit. A back-to-back start bit is detected on its falling edge with no lost bytes.
- Pixel count:
  - Increments in the cycle of the bram_we pulse.
  - busy rises in the same cycle as the first write of an image.
  - On the write at count IMG_PIXELS-1, the count wraps to 0. On the next cycle img_ready=1 for exactly one cycle and busy falls to 0 in that same cycle.
  - bram_addr holds its last value when no write is in progress.
- Latency: the bram_we pulse occurs 1 cycle after the mid-stop sample; that sample is 2 synchronizer cycles behind the pin.
- send_busy is checked only at the stop sample. A change during a byte has no effect until that point.
- A reset during a byte or mid-image discards the partial byte and image. The count returns to 0 and no img_ready is issued.
- Widths: the baud counter is $clog2(CLOCKS_PER_BAUD) bits. The pixel count is ADDR_W bits and compares to IMG_PIXELS-1, so wrap is explicit and not implicit overflow.

Test Plan:
- Sim uses IMG_PIXELS=4 and CLOCKS_PER_BAUD=50 unless noted.
- Single byte: send 0xA5 -> one bram_we with bram_addr=0, bram_din=0xA5, busy rises; no img_ready.
- Full image: send 0x01,0x02,0x03,0x04 back-to-back -> writes at addresses 0..3 with matching data; img_ready pulses exactly once, 1 cycle after the 4th write; busy falls; a 5th byte 0x55 writes to address 0.
- Framing error: send 0x3C with stop bit=0, hold rx low 300 cycles, release, then send 0x77 -> one frame_err pulse; no write for 0x3C; 0x77 written at address 0.
- Glitch: pulse rx low for 10 cycles -> no state change, no writes, no frame_err.
- Overrun: hold send_busy=1 and send 0x11 -> no write, overrun=1 sticky. Drop send_busy and send 0x22 -> written at address 0; overrun stays 1.
- Async reset: assert rst_in_n=0 mid-DATA of the 3rd byte, with no clock edge during the assertion -> outputs 0 immediately. After release, the next byte 0x9E is written at address 0 and img_ready does not pulse until 4 more bytes arrive.
